// File: rtl/fifo_sync_pkg.sv
// Shared sizing macros and operation types for the synchronous FIFO family.
// The macros sit ahead of the package so every later file in the compile sees them.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_DEPTH(aw) (1 << (aw))
`define FIFO_AFULL_DEF(aw) ((1 << (aw)) - 2)
`define FIFO_AEMPTY_DEF 2
`endif

package fifo_sync_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push_acc, input logic pop_acc);
    return fifo_op_e'({push_acc, pop_acc});
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int ADDR_L = 4,
  parameter int DATA_L = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_L-1:0] waddr,
  input  logic [DATA_L-1:0] wdata,
  input  logic [ADDR_L-1:0] raddr,
  output logic [DATA_L-1:0] rdata
);

  logic [DATA_L-1:0] mem [`FIFO_DEPTH(ADDR_L)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Parametrised synchronous FIFO with count-derived status flags, sticky error
// flags, synchronous flush and a build-time FWFT / registered-read output.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int BUF_ID     = 0,
  parameter int ADDR_L     = 4,
  parameter int DATA_L     = 64,
  parameter int FWFT       = 1,
  parameter int AFULL_LVL  = `FIFO_AFULL_DEF(ADDR_L),
  parameter int AEMPTY_LVL = `FIFO_AEMPTY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_L-1:0] din,
  input  logic              pop,
  output logic [DATA_L-1:0] dout,
  output logic              rd_valid,
  output logic [ADDR_L:0]   count,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
);

  localparam logic [ADDR_L:0] DEPTH_C  = (ADDR_L+1)'(`FIFO_DEPTH(ADDR_L));
  localparam logic [ADDR_L:0] AFULL_C  = (ADDR_L+1)'(AFULL_LVL);
  localparam logic [ADDR_L:0] AEMPTY_C = (ADDR_L+1)'(AEMPTY_LVL);

  if (ADDR_L < 1 || BUF_ID < 0) begin : g_param_chk
    $error("fifo_sync %0d: ADDR_L must be >= 1 and BUF_ID non-negative", BUF_ID);
  end

  logic [ADDR_L-1:0] rpt_q, rpt_d, wpt_q, wpt_d;
  logic [ADDR_L:0]   count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push_acc, pop_acc, ovf_evt, udf_evt;
  logic [DATA_L-1:0] ram_rdata;
  fifo_op_e          op;

  assign count  = count_q;
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign afull  = (count_q >= AFULL_C);
  assign aempty = (count_q <= AEMPTY_C);
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  // A pop on a full FIFO frees the slot the same cycle, so a concurrent push still fits.
  always_comb begin
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    if (!flush) begin
      pop_acc  = pop && !empty;
      push_acc = push && (!full || pop);
      ovf_evt  = push && full && !pop;
      udf_evt  = pop && empty;
    end
    op = fifo_op(push_acc, pop_acc);

    rpt_d   = rpt_q;
    wpt_d   = wpt_q;
    count_d = count_q;
    if (flush) begin
      rpt_d   = '0;
      wpt_d   = '0;
      count_d = '0;
    end else begin
      if (push_acc) wpt_d = wpt_q + 1'b1;
      if (pop_acc)  rpt_d = rpt_q + 1'b1;
      case (op)
        OP_PUSH: count_d = count_q + 1'b1;
        OP_POP:  count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    ovf_d = ovf_evt || (ovf_q && !err_clr);
    udf_d = udf_evt || (udf_q && !err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q   <= '0;
      wpt_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      wpt_q   <= wpt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ram #(
    .ADDR_L(ADDR_L),
    .DATA_L(DATA_L)
  ) u_ram (
    .clk  (clk),
    .we   (push_acc),
    .waddr(wpt_q),
    .wdata(din),
    .raddr(rpt_q),
    .rdata(ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout     = empty ? '0 : ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_L-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = dout_q;
      rd_valid_d = 1'b0;
      if (flush) begin
        dout_d = '0;
      end else if (pop_acc) begin
        dout_d     = ram_rdata;
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: an FWFT and a registered-read instance share stimulus and
// are compared against a queue-based model of the FIFO rules.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst, flush, push, pop, err_clr;
  logic [7:0] din;

  logic [7:0] dout_a, dout_b;
  logic       rd_valid_a, rd_valid_b;
  logic [2:0] count_a, count_b;
  logic       full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
  logic       full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_vld_r;
  logic [7:0] m_dout_r;

  always #5 clk = ~clk;

  fifo_sync #(.BUF_ID(0), .ADDR_L(2), .DATA_L(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .din(din), .pop(pop),
    .dout(dout_a), .rd_valid(rd_valid_a), .count(count_a), .full(full_a),
    .empty(empty_a), .afull(afull_a), .aempty(aempty_a), .ovf(ovf_a),
    .udf(udf_a), .err_clr(err_clr)
  );

  fifo_sync #(.BUF_ID(1), .ADDR_L(2), .DATA_L(8), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .din(din), .pop(pop),
    .dout(dout_b), .rd_valid(rd_valid_b), .count(count_b), .full(full_b),
    .empty(empty_b), .afull(afull_b), .aempty(aempty_b), .ovf(ovf_b),
    .udf(udf_b), .err_clr(err_clr)
  );

  task automatic model_clear();
    q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_vld_r  = 1'b0;
    m_dout_r = 8'h00;
  endtask

  // Drive one cycle of strobes, advance past the edge and update the model.
  task automatic step(input logic ph, input logic pp, input logic [7:0] d,
                      input logic fl = 1'b0, input logic ec = 1'b0);
    logic pv, uv;
    push = ph; pop = pp; din = d; flush = fl; err_clr = ec;
    @(posedge clk); #1;
    pv = 1'b0;
    uv = 1'b0;
    if (fl) begin
      q.delete();
      m_dout_r = 8'h00;
      m_vld_r  = 1'b0;
    end else begin
      pv = ph && (q.size() == 4) && !pp;
      uv = pp && (q.size() == 0);
      m_vld_r = 1'b0;
      if (pp && q.size() != 0) begin
        m_dout_r = q.pop_front();
        m_vld_r  = 1'b1;
      end
      if (ph && !pv) q.push_back(d);
    end
    m_ovf = pv || (m_ovf && !ec);
    m_udf = uv || (m_udf && !ec);
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({count_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a, rd_valid_a, dout_a} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_fwft got=%b want=%b", {count_a, full_a, empty_a, afull_a, aempty_a,
               ovf_a, udf_a, rd_valid_a, dout_a}, {3'd0, 7'b0101000, 8'h00});
    end
    checks++;
    if ({count_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b, rd_valid_b, dout_b} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_reg got=%b want=%b", {count_b, full_b, empty_b, afull_b, aempty_b,
               ovf_b, udf_b, rd_valid_b, dout_b}, {3'd0, 7'b0101000, 8'h00});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({count_a, empty_a} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_idle got count=%0d empty=%b want count=0 empty=1", count_a, empty_a);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4];
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, v[i]);
      checks++;
      if ({count_a, afull_a, dout_a} !== {3'(i + 1), (i + 1) >= 2, 8'h11}) begin
        failures++;
        $display("FAIL fill_%0d got count=%0d afull=%b dout=%h want count=%0d afull=%b dout=11",
                 i, count_a, afull_a, dout_a, i + 1, (i + 1) >= 2);
      end
    end
    checks++;
    if ({full_a, full_b, count_b} !== {1'b1, 1'b1, 3'd4}) begin
      failures++;
      $display("FAIL fill_full got full_a=%b full_b=%b count_b=%0d want 1 1 4", full_a, full_b, count_b);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({rd_valid_b, dout_b} !== {1'b1, v[i]}) begin
        failures++;
        $display("FAIL drain_reg_%0d got vld=%b dout=%h want vld=1 dout=%h", i, rd_valid_b, dout_b, v[i]);
      end
      checks++;
      if (dout_a !== ((i < 3) ? v[i + 1] : 8'h00)) begin
        failures++;
        $display("FAIL drain_fwft_%0d got dout=%h want %h", i, dout_a, (i < 3) ? v[i + 1] : 8'h00);
      end
    end
    checks++;
    if ({empty_a, rd_valid_a, count_a} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL drain_empty got empty=%b vld=%b count=%0d want 1 0 0", empty_a, rd_valid_a, count_a);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b0, 8'h55);
    checks++;
    if ({ovf_a, ovf_b, count_a, udf_a} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL overflow got ovf=%b%b count=%0d udf=%b want ovf=11 count=4 udf=0",
               ovf_a, ovf_b, count_a, udf_a);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({ovf_a, ovf_b, count_a} !== {1'b0, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL err_clr_ovf got ovf=%b%b count=%0d want ovf=00 count=4", ovf_a, ovf_b, count_a);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v [4];
    v = '{8'h22, 8'h33, 8'h44, 8'h66};
    step(1'b1, 1'b1, 8'h66);
    checks++;
    if ({rd_valid_b, dout_b, count_a, dout_a, ovf_a} !== {1'b1, 8'h11, 3'd4, 8'h22, 1'b0}) begin
      failures++;
      $display("FAIL full_push_pop got vld=%b dout_b=%h count=%0d dout_a=%h ovf=%b want 1 11 4 22 0",
               rd_valid_b, dout_b, count_a, dout_a, ovf_a);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (dout_b !== v[i]) begin
        failures++;
        $display("FAIL after_full_order_%0d got %h want %h", i, dout_b, v[i]);
      end
    end
    step(1'b1, 1'b1, 8'h77);
    checks++;
    if ({udf_a, udf_b, count_a, dout_a, rd_valid_b} !== {1'b1, 1'b1, 3'd1, 8'h77, 1'b0}) begin
      failures++;
      $display("FAIL empty_push_pop got udf=%b%b count=%0d dout_a=%h vld_b=%b want 11 1 77 0",
               udf_a, udf_b, count_a, dout_a, rd_valid_b);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({udf_a, udf_b} !== 2'b00) begin
      failures++;
      $display("FAIL err_clr_udf got udf=%b%b want 00", udf_a, udf_b);
    end
    step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_registered_read();
    step(1'b1, 1'b0, 8'hA5);
    checks++;
    if ({rd_valid_b, rd_valid_a, dout_a} !== {1'b0, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL reg_before_pop got vld_b=%b vld_a=%b dout_a=%h want 0 1 a5", rd_valid_b, rd_valid_a, dout_a);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({rd_valid_b, dout_b} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL reg_n1 got vld=%b dout=%h want vld=1 dout=a5", rd_valid_b, dout_b);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({rd_valid_b, dout_b} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL reg_n2 got vld=%b dout=%h want vld=0 dout=a5 held", rd_valid_b, dout_b);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] nxt;
    nxt = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    for (int i = 2; i < 12; i++) begin
      if (i < 10) step(1'b1, 1'b1, 8'(i));
      else        step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({rd_valid_b, dout_b, (count_a <= 3'd3)} !== {1'b1, nxt, 1'b1}) begin
        failures++;
        $display("FAIL wrap_%0d got vld=%b dout=%h count=%0d want vld=1 dout=%h count<=3",
                 i, rd_valid_b, dout_b, count_a, nxt);
      end
      nxt = nxt + 8'h01;
    end
    checks++;
    if ({ovf_a, udf_a, ovf_b, udf_b, count_a} !== {4'b0000, 3'd0}) begin
      failures++;
      $display("FAIL wrap_flags got ovf/udf=%b%b%b%b count=%0d want 0000 0", ovf_a, udf_a, ovf_b, udf_b, count_a);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b0, 8'h99, 1'b1);
    checks++;
    if ({count_a, empty_a, ovf_a, udf_a, dout_a, rd_valid_b, dout_b, count_b} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0}) begin
      failures++;
      $display("FAIL flush got count=%0d empty=%b ovf=%b udf=%b dout_a=%h vld_b=%b dout_b=%h want 0 1 0 0 00 0 00",
               count_a, empty_a, ovf_a, udf_a, dout_a, rd_valid_b, dout_b);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    checks++;
    if ({udf_a, udf_b, count_a} !== {2'b00, 3'd0}) begin
      failures++;
      $display("FAIL flush_pop_empty got udf=%b%b count=%0d want 00 0", udf_a, udf_b, count_a);
    end
  endtask

  task automatic test_random();
    int r;
    logic ph, pp, fl, ec;
    logic [8:0] exp_st;
    logic [7:0] head;
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 99);
      ph = (r < 60);
      pp = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      ec = ($urandom_range(0, 99) < 6);
      step(ph, pp, 8'($urandom), fl, ec);
      exp_st = {3'(q.size()), q.size() == 4, q.size() == 0, q.size() >= 2, q.size() <= 2, m_ovf, m_udf};
      head   = (q.size() != 0) ? q[0] : 8'h00;
      checks++;
      if ({count_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a} !== exp_st) begin
        failures++;
        $display("FAIL rand_status_fwft cyc=%0d got=%b want=%b", n,
                 {count_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a}, exp_st);
      end
      checks++;
      if ({rd_valid_a, dout_a} !== {q.size() != 0, head}) begin
        failures++;
        $display("FAIL rand_out_fwft cyc=%0d got vld=%b dout=%h want vld=%b dout=%h", n,
                 rd_valid_a, dout_a, q.size() != 0, head);
      end
      checks++;
      if ({count_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b} !== exp_st) begin
        failures++;
        $display("FAIL rand_status_reg cyc=%0d got=%b want=%b", n,
                 {count_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b}, exp_st);
      end
      checks++;
      if ({rd_valid_b, dout_b} !== {m_vld_r, m_dout_r}) begin
        failures++;
        $display("FAIL rand_out_reg cyc=%0d got vld=%b dout=%h want vld=%b dout=%h", n,
                 rd_valid_b, dout_b, m_vld_r, m_dout_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hE1);
    step(1'b1, 1'b1, 8'hE2);
    push = 1'b1; din = 8'hE3;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({count_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a, rd_valid_a, dout_a} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset_fwft got count=%0d empty=%b vld=%b dout=%h want 0 1 0 00",
               count_a, empty_a, rd_valid_a, dout_a);
    end
    checks++;
    if ({count_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b, rd_valid_b, dout_b} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset_reg got count=%0d empty=%b vld=%b dout=%h want 0 1 0 00",
               count_b, empty_b, rd_valid_b, dout_b);
    end
    @(posedge clk); #1;
    checks++;
    if ({count_a, count_b} !== {3'd0, 3'd0}) begin
      failures++;
      $display("FAIL push_during_reset got count=%0d/%0d want 0/0", count_a, count_b);
    end
    rst = 1'b0;
    push = 1'b0;
    model_clear();
    step(1'b1, 1'b0, 8'h5A);
    checks++;
    if ({count_a, dout_a} !== {3'd1, 8'h5A}) begin
      failures++;
      $display("FAIL after_reset_push got count=%0d dout=%h want 1 5a", count_a, dout_a);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = 8'h00;
    model_clear();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_registered_read();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
